lcd_line_draw: RTL and testbench
================================

Name: lcd_line_draw

Overview:
- Line-draw GPU front end for the SPI ST7789 pixel core.
- Accepts a line command (two endpoints plus an RGB565 colour) and walks it with integer Bresenham.
- Issues one plot request per pixel over the pixel core's plot/busy handshake.
- Sits directly upstream of the pixel core; its x/y/color/plot outputs connect one-to-one to that core's inputs.

Parameters:
- c_coord_bits, 16: width of coordinate ports; signed two's complement.
- c_x_size, 240: screen width in pixels; used only by the clip feature.
- c_y_size, 240: screen height in pixels; used only by the clip feature.

Ports:
- clk  in  1  system clock; same clock as the pixel core.
- reset  in  1  synchronous, active-high.
- start  in  1  line request; sampled only when ready=1.
- x0, y0, x1, y1  in  c_coord_bits each  signed endpoints.
- color  in  16  RGB565 line colour.
- ready  out  1  high in IDLE; command may be accepted.
- done  out  1  one-cycle pulse when a line completes.
- pixel_busy  in  1  busy from the pixel core.
- plot  out  1  one-cycle plot request to the pixel core.
- x, y  out  16  pixel coordinate; zero-extended or truncated from c_coord_bits.
- color_out  out  16  pixel colour.
- pix_count  out  16  pixels plotted in the current/last line; saturates at 16'hFFFF.

Behaviour:
- Reset values: ready=1, done=0, plot=0, x=0, y=0, color_out=0, pix_count=0, state=IDLE. Reset mid-line aborts immediately; no further plot is issued.
- Reset has priority over all other inputs.

States and transitions:
- IDLE: ready=1. start=1 latches x0/y0/x1/y1/color, clears pix_count, goes to SETUP. Without start, stay in IDLE.
- SETUP (1 cycle):
  - dx=|x1-x0| and dy=-|y1-y0|, each c_coord_bits+1 bits.
  - sx=+1 if x0<x1 else -1; sy likewise.
  - err=dx+dy, c_coord_bits+2 bits signed.
  - cur=(x0,y0). Go to ISSUE.
- ISSUE: when pixel_busy=0, drive x/y/color_out from cur, plot=1 for exactly this one cycle, increment pix_count, go to HOLD. While pixel_busy=1, wait.
- HOLD (1 cycle): pixel_busy is ignored, because the pixel core raises busy one cycle after sampling plot. Go to WAIT.
- WAIT: stay while pixel_busy=1. When it is 0:
  - if cur==(x1,y1), pulse done=1 and go to IDLE;
  - otherwise go to STEP.
- STEP (1 cycle):
  - e2=2*err.
  - If e2>=dy: err+=dy, cur.x+=sx.
  - If e2<=dx: err+=dx, cur.y+=sy.
  - Both updates use the old err and are applied in the same cycle. Go to ISSUE.

Rules:
- start is ignored while ready=0; it is not queued.
- start and reset in the same cycle: reset wins.
- x/y/color_out hold their value from plot until the next plot.
- plot is never high while pixel_busy=1 in the same cycle.
- Degenerate line (x0==x1 and y0==y1): exactly one pixel, then done.
- Pixel count per line = max(|x1-x0|,|y1-y0|)+1.
- Endpoint order is preserved: the first pixel is (x0,y0) and the last is (x1,y1).
- Signed arithmetic throughout; the extra bits on dx/dy/err guarantee no overflow for any endpoint pair.
- Pixel core busy high after reset (its init sequence): the first ISSUE simply waits.
- Latency from start to first plot: 2 cycles if pixel_busy=0 (SETUP, then ISSUE).

Optional Feature:
- Macro: LCD_LINE_CLIP_EN.
- With LCD_LINE_CLIP_EN defined:
  - In ISSUE, a cur with x<0, y<0, x>=c_x_size or y>=c_y_size does not assert plot and does not increment pix_count.
  - The FSM passes directly to the endpoint check (done, or STEP) without HOLD/WAIT; one cycle per clipped pixel.
- Without the macro: every pixel is plotted; coordinates are truncated to 16 bits unsigned onto x/y.

Test Plan:
- Bench model: pixel core raises busy 1 cycle after plot and holds it for 5 cycles. Stimulus start (0,0)->(5,2), color=16'hF800 -> 6 plots at (0,0),(1,0),(2,1),(3,1),(4,2),(5,2); pix_count=6; one done pulse; ready=1 after.
- Steep line (10,10)->(8,15) -> 6 plots, y stepping 10..15, x=10,10,9,9,8,8; last pixel (8,15).
- Point (7,7)->(7,7) -> exactly 1 plot at (7,7), then done. Also: pixel_busy held high 100 cycles after reset -> first plot occurs only once busy falls, never while busy=1.
- Reset asserted during WAIT of the 3rd pixel of (0,0)->(20,0) -> plot=0, ready=1, x=y=0 next cycle; no further plots. A second start pulse issued mid-line is ignored: total plots stay 21 on a clean rerun.
- LCD_LINE_CLIP_EN, (-2,0)->(2,0) -> plots only (0,0),(1,0),(2,0); pix_count=3; done pulses once.
- Without clip, (0,0)->(239,239) with zero-latency busy model -> 240 plots, each a single-cycle pulse, diagonal x==y.

Source files
------------

// File: rtl/lcd_line_draw.sv
// lcd_line_draw: line-draw front end for the SPI ST7789 pixel core.
// Takes a line command (two signed endpoints plus an RGB565 colour) and
// walks it with integer Bresenham. Each pixel is issued as one plot pulse
// over the pixel core's plot/busy handshake.
//
// Ports:
//   clk, reset          system clock; synchronous active-high reset
//   start               line request, sampled only while ready=1
//   x0, y0, x1, y1      signed endpoints (c_coord_bits wide)
//   color               RGB565 line colour
//   ready               high while idle; a command may be accepted
//   done                one-cycle pulse when a line completes
//   pixel_busy          busy from the pixel core
//   plot                one-cycle plot request to the pixel core
//   x, y, color_out     pixel coordinate and colour; held between plots
//   pix_count           pixels plotted in the current/last line (saturating)
//
// Optional build macro: LCD_LINE_CLIP_EN. When it is defined, pixels off the
// c_x_size x c_y_size screen are skipped without a plot and cost one cycle.
module lcd_line_draw #(
  parameter int unsigned c_coord_bits = 16,
  parameter int unsigned c_x_size     = 240,
  parameter int unsigned c_y_size     = 240
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic signed [c_coord_bits-1:0] x0,
  input  logic signed [c_coord_bits-1:0] y0,
  input  logic signed [c_coord_bits-1:0] x1,
  input  logic signed [c_coord_bits-1:0] y1,
  input  logic        [15:0]             color,
  output logic                           ready,
  output logic                           done,
  input  logic                           pixel_busy,
  output logic                           plot,
  output logic        [15:0]             x,
  output logic        [15:0]             y,
  output logic        [15:0]             color_out,
  output logic        [15:0]             pix_count
);

  localparam int unsigned c_d_bits  = c_coord_bits + 1;  // |delta| and -|delta|
  localparam int unsigned c_e_bits  = c_coord_bits + 2;  // Bresenham error
  localparam int unsigned c_e2_bits = c_coord_bits + 3;  // 2*err

`ifdef LCD_LINE_CLIP_EN
  localparam bit clip_en = 1'b1;
`else
  localparam bit clip_en = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_ISSUE, S_HOLD, S_WAIT, S_STEP
  } state_t;

  state_t                         state_q, state_d;
  logic signed [c_coord_bits-1:0] x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
  logic        [15:0]             col_q, col_d;
  logic signed [c_d_bits-1:0]     dx_q, dx_d, dy_q, dy_d;
  logic                           sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
  logic signed [c_e_bits-1:0]     err_q, err_d;
  logic signed [c_coord_bits-1:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic        [15:0]             x_q, x_d, y_q, y_d, color_out_q, color_out_d;
  logic        [15:0]             pix_count_q, pix_count_d;
  logic                           plot_q, plot_d, done_q, done_d, ready_q, ready_d;

  logic signed [c_d_bits-1:0]     ddx_c, ddy_c, adx_c, ady_c;
  logic signed [c_e2_bits-1:0]    e2_c;
  logic                           step_x_c, step_y_c, at_end_c, in_screen_c, clip_c;

  // Setup arithmetic: widened deltas cannot overflow for any endpoint pair.
  always_comb begin
    ddx_c = c_d_bits'(x1_q) - c_d_bits'(x0_q);
    ddy_c = c_d_bits'(y1_q) - c_d_bits'(y0_q);
    adx_c = (ddx_c < 0) ? -ddx_c : ddx_c;
    ady_c = (ddy_c < 0) ? -ddy_c : ddy_c;
  end

  // Step decisions both come from the current err.
  always_comb begin
    e2_c     = $signed({err_q, 1'b0});
    step_x_c = (e2_c >= c_e2_bits'(dy_q));
    step_y_c = (e2_c <= c_e2_bits'(dx_q));
    at_end_c = (cur_x_q == x1_q) && (cur_y_q == y1_q);
  end

  // On-screen test; only consulted when clipping is built in.
  always_comb begin
    in_screen_c = !cur_x_q[c_coord_bits-1] && !cur_y_q[c_coord_bits-1] &&
                  ({1'b0, cur_x_q} < c_d_bits'(c_x_size)) &&
                  ({1'b0, cur_y_q} < c_d_bits'(c_y_size));
    clip_c      = clip_en && !in_screen_c;
  end

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    x0_d        = x0_q;
    y0_d        = y0_q;
    x1_d        = x1_q;
    y1_d        = y1_q;
    col_d       = col_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    sx_neg_d    = sx_neg_q;
    sy_neg_d    = sy_neg_q;
    err_d       = err_q;
    cur_x_d     = cur_x_q;
    cur_y_d     = cur_y_q;
    x_d         = x_q;
    y_d         = y_q;
    color_out_d = color_out_q;
    pix_count_d = pix_count_q;
    plot_d      = 1'b0;
    done_d      = 1'b0;
    ready_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          x0_d        = x0;
          y0_d        = y0;
          x1_d        = x1;
          y1_d        = y1;
          col_d       = color;
          pix_count_d = '0;
          state_d     = S_SETUP;
        end
      end

      S_SETUP: begin
        dx_d     = adx_c;
        dy_d     = -ady_c;
        sx_neg_d = !(x0_q < x1_q);
        sy_neg_d = !(y0_q < y1_q);
        err_d    = c_e_bits'(adx_c) - c_e_bits'(ady_c);
        cur_x_d  = x0_q;
        cur_y_d  = y0_q;
        state_d  = S_ISSUE;
      end

      S_ISSUE: begin
        if (clip_c) begin
          // Off-screen pixel: skip the handshake entirely.
          done_d  = at_end_c;
          state_d = at_end_c ? S_IDLE : S_STEP;
        end else if (!pixel_busy) begin
          plot_d      = 1'b1;
          x_d         = 16'($unsigned(cur_x_q));
          y_d         = 16'($unsigned(cur_y_q));
          color_out_d = col_q;
          pix_count_d = (pix_count_q == 16'hFFFF) ? pix_count_q : pix_count_q + 16'd1;
          state_d     = S_HOLD;
        end
      end

      // The core raises busy one cycle after it samples plot, so busy is
      // not meaningful here yet.
      S_HOLD: state_d = S_WAIT;

      S_WAIT: begin
        if (!pixel_busy) begin
          done_d  = at_end_c;
          state_d = at_end_c ? S_IDLE : S_STEP;
        end
      end

      S_STEP: begin
        if (step_x_c) begin
          err_d   = err_d + c_e_bits'(dy_q);
          cur_x_d = sx_neg_q ? cur_x_q - c_coord_bits'(1) : cur_x_q + c_coord_bits'(1);
        end
        if (step_y_c) begin
          err_d   = err_d + c_e_bits'(dx_q);
          cur_y_d = sy_neg_q ? cur_y_q - c_coord_bits'(1) : cur_y_q + c_coord_bits'(1);
        end
        state_d = S_ISSUE;
      end

      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      x0_q        <= '0;
      y0_q        <= '0;
      x1_q        <= '0;
      y1_q        <= '0;
      col_q       <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      sx_neg_q    <= 1'b0;
      sy_neg_q    <= 1'b0;
      err_q       <= '0;
      cur_x_q     <= '0;
      cur_y_q     <= '0;
      x_q         <= '0;
      y_q         <= '0;
      color_out_q <= '0;
      pix_count_q <= '0;
      plot_q      <= 1'b0;
      done_q      <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      x0_q        <= x0_d;
      y0_q        <= y0_d;
      x1_q        <= x1_d;
      y1_q        <= y1_d;
      col_q       <= col_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      sx_neg_q    <= sx_neg_d;
      sy_neg_q    <= sy_neg_d;
      err_q       <= err_d;
      cur_x_q     <= cur_x_d;
      cur_y_q     <= cur_y_d;
      x_q         <= x_d;
      y_q         <= y_d;
      color_out_q <= color_out_d;
      pix_count_q <= pix_count_d;
      plot_q      <= plot_d;
      done_q      <= done_d;
      ready_q     <= ready_d;
    end
  end

  assign ready     = ready_q;
  assign done      = done_q;
  assign plot      = plot_q;
  assign x         = x_q;
  assign y         = y_q;
  assign color_out = color_out_q;
  assign pix_count = pix_count_q;

endmodule

// File: tb/tb_lcd_line_draw.sv
// Self-checking bench for lcd_line_draw with a simple pixel-core busy model.
module tb_lcd_line_draw;

  typedef logic [7:0][15:0] px8_t;

  typedef struct packed {
    logic [15:0] x0, y0, x1, y1, color;
    logic [7:0]  n;
    px8_t        ex;
    px8_t        ey;
  } vec_t;

  logic               clk = 1'b0;
  logic               reset, start;
  logic signed [15:0] x0, y0, x1, y1;
  logic        [15:0] color;
  logic               ready, done, pixel_busy, plot;
  logic        [15:0] x, y, color_out, pix_count;

  logic       force_busy;
  logic [7:0] busy_len;
  logic [7:0] busy_cnt;
  logic       prev_plot = 1'b0;
  int         total = 0;
  int         bad = 0;
  int         done_cnt = 0;
  logic [15:0] cap_x[$], cap_y[$], cap_c[$];
  vec_t       vecs[7];

  always #5 clk = ~clk;

  lcd_line_draw #(.c_coord_bits(16), .c_x_size(240), .c_y_size(240)) dut (
    .clk(clk), .reset(reset), .start(start),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .color(color),
    .ready(ready), .done(done), .pixel_busy(pixel_busy), .plot(plot),
    .x(x), .y(y), .color_out(color_out), .pix_count(pix_count)
  );

  // Pixel core model: busy rises the cycle after plot and lasts busy_len cycles.
  assign pixel_busy = force_busy | (busy_cnt != 8'd0);
  always @(posedge clk) begin
    if (reset)                busy_cnt <= 8'd0;
    else if (plot)            busy_cnt <= busy_len;
    else if (busy_cnt != 8'd0) busy_cnt <= busy_cnt - 8'd1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Capture every plot and check handshake rules as they happen.
  always @(negedge clk) begin
    if (plot) begin
      chk("plot_while_busy", 32'(pixel_busy), 32'd0);
      chk("plot_single_cycle", 32'(prev_plot), 32'd0);
      cap_x.push_back(x);
      cap_y.push_back(y);
      cap_c.push_back(color_out);
    end
    if (done) done_cnt++;
    prev_plot = plot;
  end

  function automatic px8_t l8(input int a0, a1, a2, a3, a4, a5, a6, a7);
    px8_t r;
    r[0] = 16'(a0); r[1] = 16'(a1); r[2] = 16'(a2); r[3] = 16'(a3);
    r[4] = 16'(a4); r[5] = 16'(a5); r[6] = 16'(a6); r[7] = 16'(a7);
    return r;
  endfunction

  function automatic vec_t mk(input int ax0, ay0, ax1, ay1, input logic [15:0] c,
                              input int n, input px8_t ex, input px8_t ey);
    vec_t v;
    v.x0 = 16'(ax0); v.y0 = 16'(ay0); v.x1 = 16'(ax1); v.y1 = 16'(ay1);
    v.color = c; v.n = 8'(n); v.ex = ex; v.ey = ey;
    return v;
  endfunction

  task automatic start_line(input logic [15:0] ax0, ay0, ax1, ay1, acol);
    cap_x.delete(); cap_y.delete(); cap_c.delete();
    done_cnt = 0;
    x0 = ax0; y0 = ay0; x1 = ax1; y1 = ay1; color = acol;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int cyc = 0;
    while (done_cnt == 0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    chk({name, "_timeout"}, 32'(cyc >= budget), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_plots(input string name, input int n, input int budget);
    int cyc = 0;
    while (cap_x.size() < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    chk({name, "_timeout"}, 32'(cyc >= budget), 32'd0);
  endtask

  task automatic run_vec(input int k);
    vec_t v = vecs[k];
    string nm = $sformatf("v%0d", k);
    start_line(v.x0, v.y0, v.x1, v.y1, v.color);
    wait_done(nm, 2000);
    chk({nm, "_plots"}, 32'(cap_x.size()), 32'(v.n));
    chk({nm, "_pix_count"}, 32'(pix_count), 32'(v.n));
    chk({nm, "_done_pulses"}, 32'(done_cnt), 32'd1);
    chk({nm, "_ready"}, 32'(ready), 32'd1);
    for (int i = 0; i < int'(v.n) && i < cap_x.size(); i++) begin
      chk($sformatf("%s_x%0d", nm, i), 32'(cap_x[i]), 32'(v.ex[i]));
      chk($sformatf("%s_y%0d", nm, i), 32'(cap_y[i]), 32'(v.ey[i]));
      chk($sformatf("%s_c%0d", nm, i), 32'(cap_c[i]), 32'(v.color));
    end
  endtask

  initial begin
    vecs[0] = mk(0, 0, 5, 2, 16'hF800, 6, l8(0, 1, 2, 3, 4, 5, 0, 0), l8(0, 0, 1, 1, 2, 2, 0, 0));
    vecs[1] = mk(10, 10, 8, 15, 16'h07E0, 6, l8(10, 10, 9, 9, 8, 8, 0, 0), l8(10, 11, 12, 13, 14, 15, 0, 0));
    vecs[2] = mk(7, 7, 7, 7, 16'h001F, 1, l8(7, 0, 0, 0, 0, 0, 0, 0), l8(7, 0, 0, 0, 0, 0, 0, 0));
    vecs[3] = mk(5, 2, 0, 0, 16'hFFFF, 6, l8(5, 4, 3, 2, 1, 0, 0, 0), l8(2, 2, 1, 1, 0, 0, 0, 0));
    vecs[4] = mk(3, 4, 0, 4, 16'h1234, 4, l8(3, 2, 1, 0, 0, 0, 0, 0), l8(4, 4, 4, 4, 0, 0, 0, 0));
    vecs[5] = mk(1, 0, 1, 3, 16'hABCD, 4, l8(1, 1, 1, 1, 0, 0, 0, 0), l8(0, 1, 2, 3, 0, 0, 0, 0));
`ifdef LCD_LINE_CLIP_EN
    vecs[6] = mk(-2, 0, 2, 0, 16'h5555, 3, l8(0, 1, 2, 0, 0, 0, 0, 0), l8(0, 0, 0, 0, 0, 0, 0, 0));
`else
    vecs[6] = mk(-2, 0, 2, 0, 16'h5555, 5, l8(-2, -1, 0, 1, 2, 0, 0, 0), l8(0, 0, 0, 0, 0, 0, 0, 0));
`endif

    reset = 1'b1; start = 1'b0; force_busy = 1'b1; busy_len = 8'd5;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0; color = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_plot", 32'(plot), 32'd0);
    chk("rst_xy", {x, y}, 32'd0);
    chk("rst_color_out", 32'(color_out), 32'd0);
    chk("rst_pix_count", 32'(pix_count), 32'd0);
    reset = 1'b0;

    // Core still initialising: the first pixel must wait for busy to fall.
    start_line(16'd7, 16'd7, 16'd7, 16'd7, 16'h0F0F);
    repeat (100) @(negedge clk);
    chk("busy_init_no_plot", 32'(cap_x.size()), 32'd0);
    chk("busy_init_not_ready", 32'(ready), 32'd0);
    force_busy = 1'b0;
    wait_done("busy_init", 200);
    chk("busy_init_plots", 32'(cap_x.size()), 32'd1);
    if (cap_x.size() > 0) chk("busy_init_xy", {cap_x[0], cap_y[0]}, {16'd7, 16'd7});
    chk("busy_init_done", 32'(done_cnt), 32'd1);

    for (int k = 0; k < 7; k++) run_vec(k);

    // Start-to-first-plot latency with the core idle.
    start_line(16'd2, 16'd2, 16'd3, 16'd3, 16'h0F0F);
    chk("lat_setup_plot", 32'(plot), 32'd0);
    @(negedge clk);
    chk("lat_issue_plot", 32'(plot), 32'd0);
    @(negedge clk);
    chk("lat_plot", 32'(plot), 32'd1);
    chk("lat_xy", {x, y}, {16'd2, 16'd2});
    chk("lat_color", 32'(color_out), 32'h0F0F);
    wait_done("lat", 200);
    chk("lat_plots", 32'(cap_x.size()), 32'd2);

    // Reset while waiting on the 3rd pixel, with start asserted alongside.
    start_line(16'd0, 16'd0, 16'd20, 16'd0, 16'h00FF);
    wait_plots("rst_mid", 3, 500);
    @(negedge clk);
    reset = 1'b1; start = 1'b1;
    x0 = 16'd9; y0 = 16'd9; x1 = 16'd12; y1 = 16'd9;
    @(negedge clk);
    chk("rst_mid_plot", 32'(plot), 32'd0);
    chk("rst_mid_ready", 32'(ready), 32'd1);
    chk("rst_mid_xy", {x, y}, 32'd0);
    chk("rst_mid_pix_count", 32'(pix_count), 32'd0);
    reset = 1'b0; start = 1'b0;
    repeat (60) @(negedge clk);
    chk("rst_mid_no_more_plots", 32'(cap_x.size()), 32'd3);
    chk("rst_mid_no_done", 32'(done_cnt), 32'd0);
    chk("rst_mid_idle", 32'(ready), 32'd1);

    // Clean rerun with a second start mid-line that must be ignored.
    start_line(16'd0, 16'd0, 16'd20, 16'd0, 16'h00FF);
    wait_plots("rerun_mid", 5, 500);
    x0 = 16'd100; y0 = 16'd50; x1 = 16'd101; y1 = 16'd51; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("rerun", 3000);
    chk("rerun_plots", 32'(cap_x.size()), 32'd21);
    chk("rerun_pix_count", 32'(pix_count), 32'd21);
    for (int i = 0; i < 21 && i < cap_x.size(); i++)
      chk($sformatf("rerun_xy%0d", i), {cap_x[i], cap_y[i]}, {16'(i), 16'd0});
    repeat (20) @(negedge clk);
    chk("rerun_no_second_line", 32'(cap_x.size()), 32'd21);
    chk("rerun_done_pulses", 32'(done_cnt), 32'd1);

    // Full-screen diagonal against a zero-latency core.
    busy_len = 8'd0;
    start_line(16'd0, 16'd0, 16'd239, 16'd239, 16'hFFE0);
    wait_done("diag", 5000);
    chk("diag_plots", 32'(cap_x.size()), 32'd240);
    chk("diag_pix_count", 32'(pix_count), 32'd240);
    chk("diag_done_pulses", 32'(done_cnt), 32'd1);
    for (int i = 0; i < 240 && i < cap_x.size(); i++)
      chk($sformatf("diag_xy%0d", i), {cap_x[i], cap_y[i]}, {16'(i), 16'(i)});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
